// File: rtl/machine_ctrl_pkg.sv
// Shared types and constants for the machine controller: sequencer state
// encoding, default step stagger and the fault-cause width helper.
package machine_ctrl_pkg;

  localparam int STAGGER_DEFAULT = 1000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_STARTING = 3'd1,
    ST_RUNNING  = 3'd2,
    ST_STOPPING = 3'd3,
    ST_FAULT    = 3'd4
  } seq_state_e;

  function automatic int err_cause_width(input int n_mot, input int n_sens);
    return n_mot + n_sens;
  endfunction

endpackage

// File: rtl/motor_start_sequencer_if.sv
// Command/status bundle between the host side and the motor start sequencer.
interface motor_start_sequencer_if
  import machine_ctrl_pkg::*;
#(
  parameter int N_MOT  = 5,
  parameter int N_SENS = 3
);

  logic                                       START;
  logic                                       STOP;
  logic                                       FAULT_CLR;
  logic [N_MOT-1:0]                           MOT_ERR;
  logic [N_SENS-1:0]                          FAIL_SENSn;
  logic [N_MOT-1:0]                           MOT_ENA;
  logic                                       RUNNING;
  logic                                       BUSY;
  logic                                       FAULT;
  logic [err_cause_width(N_MOT, N_SENS)-1:0]  ERR_CAUSE;

  modport master (
    output START, STOP, FAULT_CLR, MOT_ERR, FAIL_SENSn,
    input  MOT_ENA, RUNNING, BUSY, FAULT, ERR_CAUSE
  );

  modport slave (
    input  START, STOP, FAULT_CLR, MOT_ERR, FAIL_SENSn,
    output MOT_ENA, RUNNING, BUSY, FAULT, ERR_CAUSE
  );

endinterface

// File: rtl/step_timer.sv
// Free-running step timer: counts enabled cycles and pulses tc once every
// PERIOD enabled cycles; clr restarts the count from zero.
module step_timer #(
  parameter int PERIOD = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(PERIOD + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // tc depends only on the registered count, so callers may feed clr from tc
  always_comb begin
    tc    = en && (cnt_q == CW'(PERIOD - 1));
    cnt_d = cnt_q;
    if (clr || tc) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/motor_start_sequencer.sv
// Staggered motor power-up/power-down sequencer with one-clock fault trip and
// latched fault cause held until an explicit, clean acknowledge.
module motor_start_sequencer
  import machine_ctrl_pkg::*;
#(
  parameter int N_MOT   = 5,
  parameter int N_SENS  = 3,
  parameter int STAGGER = STAGGER_DEFAULT
) (
  input  logic                    CLK,
  input  logic                    RST,
  motor_start_sequencer_if.slave  bus
);

  localparam int CW = err_cause_width(N_MOT, N_SENS);

  seq_state_e       state_q, state_d;
  logic [N_MOT-1:0] ena_q, ena_d;
  logic [CW-1:0]    cause_q, cause_d;
  logic             running_q, running_d;
  logic             busy_q, busy_d;
  logic             fault_q, fault_d;
  logic             trip;
  logic             tc;
  logic             tmr_en;
  logic             tmr_clr;

  assign trip    = (|bus.MOT_ERR) || !(&bus.FAIL_SENSn);
  assign tmr_en  = (state_q == ST_STARTING) || (state_q == ST_STOPPING);
  assign tmr_clr = (state_d != state_q) || (ena_d != ena_q);

  step_timer #(
    .PERIOD (STAGGER)
  ) u_step_timer (
    .clk (CLK),
    .rst (RST),
    .clr (tmr_clr),
    .en  (tmr_en),
    .tc  (tc)
  );

  // Enables form a thermometer code: fill by shifting ones in at the LSB,
  // drain by shifting right so the highest set bit always drops first.
  always_comb begin
    state_d = state_q;
    ena_d   = ena_q;
    cause_d = cause_q;

    if (trip && (state_q != ST_FAULT)) begin
      state_d = ST_FAULT;
      ena_d   = '0;
      cause_d = {~bus.FAIL_SENSn, bus.MOT_ERR};
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.START && !bus.STOP) begin
            state_d = ST_STARTING;
            ena_d   = N_MOT'(1);
          end
        end
        ST_STARTING, ST_RUNNING: begin
          if (bus.STOP) begin
            ena_d   = ena_q >> 1;
            state_d = (ena_d == '0) ? ST_IDLE : ST_STOPPING;
          end else if ((state_q == ST_STARTING) && tc) begin
            if (ena_q[N_MOT-1]) begin
              state_d = ST_RUNNING;
            end else begin
              ena_d = (ena_q << 1) | N_MOT'(1);
            end
          end
        end
        ST_STOPPING: begin
          if (tc) begin
            ena_d = ena_q >> 1;
            if (ena_d == '0) begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_FAULT: begin
          if (bus.FAULT_CLR && !trip) begin
            state_d = ST_IDLE;
            cause_d = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          ena_d   = '0;
        end
      endcase
    end

    running_d = (state_d == ST_RUNNING);
    busy_d    = (state_d == ST_STARTING) || (state_d == ST_STOPPING);
    fault_d   = (state_d == ST_FAULT);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      ena_q     <= '0;
      cause_q   <= '0;
      running_q <= 1'b0;
      busy_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ena_q     <= ena_d;
      cause_q   <= cause_d;
      running_q <= running_d;
      busy_q    <= busy_d;
      fault_q   <= fault_d;
    end
  end

  assign bus.MOT_ENA   = ena_q;
  assign bus.RUNNING   = running_q;
  assign bus.BUSY      = busy_q;
  assign bus.FAULT     = fault_q;
  assign bus.ERR_CAUSE = cause_q;

endmodule
